uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

UART receiver for the echo path: recovers 8N1 bytes from the board's RX pin and presents each byte on a one-entry valid/ready output. It sits directly upstream of the transmit controller. Its `rx_valid`/`rx_data` drive that controller's `send`/`send_data`, and the controller's `ready` drives `rx_ready`. Bit timing matches the transmitter: one bit is `BIT_TMR_MAX+1` clocks.

## Interface
- `BIT_TMR_MAX`, 10416: last timer value of one bit period (100 MHz / 9600 Bd − 1); must fit in 14 bits.
- `HALF_MAX`, `BIT_TMR_MAX/2` (integer division): last timer value of the start-bit half period.
- `CLK` input 1: single clock for all logic.
- `RST` input 1: reset, synchronous, active-high.
- `UART_RX` input 1: asynchronous serial line, idle high.
- `rx_data` output 8: received byte; stable while `rx_valid`=1.
- `rx_valid` output 1: byte available; held until accepted.
- `rx_ready` input 1: consumer accepts the byte when `rx_valid`&`rx_ready`.
- `rx_err` output 1: one-cycle pulse on framing error (stop bit sampled 0).
- `rx_overrun` output 1: one-cycle pulse when a good byte is dropped because the holding register is full.

## Operation
- Input synchronizer: two flops; reset value 1. Its output is `rx_s`. Nothing else samples `UART_RX`.
- Timer: 14-bit up-counter. It is cleared on every state change and on every sample point, and it increments otherwise.
- FSM states:
  - IDLE: if `rx_s`=0, go to START with the timer at 0.
  - START: when timer==`HALF_MAX`, sample `rx_s`. If 0, go to DATA with the bit index at 0. If 1, this is a false start; go to IDLE with no output.
  - DATA: when timer==`BIT_TMR_MAX`, sample `rx_s` into shift-register bit `index` (LSB first) and increment the index. After bit 7, go to STOP.
  - STOP: when timer==`BIT_TMR_MAX`, sample `rx_s`.
    - If 1: deliver the byte (see handshake) and go to IDLE.
    - If 0: pulse `rx_err`, discard the byte and go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from retriggering.
  - Illegal encodings go to IDLE.
- Output handshake (one-entry holding register):
  - Delivery with `rx_valid`=0: load `rx_data` and set `rx_valid`=1.
  - `rx_valid`&`rx_ready` with no simultaneous delivery: clear `rx_valid` on the next edge.
  - Delivery in the same cycle as accept: load the new byte; `rx_valid` stays 1.
  - Delivery with `rx_valid`=1 and no accept: drop the new byte, pulse `rx_overrun`, and leave `rx_data` unchanged.
- `rx_err` and `rx_overrun` are never asserted for more than one cycle per event.
- Reset values: `rx_data`=0x00, `rx_valid`=0, `rx_err`=0, `rx_overrun`=0. After reset the FSM is in IDLE, the timer and index are 0, and the synchronizer holds 1.
- `RST` mid-frame aborts immediately. The first start edge after reset release is received normally.

## Timing
- E0 is the first CLK edge at which the first synchronizer flop captures 0.
  - The FSM enters START at E2.
  - The start bit is sampled at E(3+`HALF_MAX`).
  - Data bit k is sampled at E(3+`HALF_MAX`+(k+1)(`BIT_TMR_MAX`+1)), for k=0..7.
  - The stop bit is sampled at E(3+`HALF_MAX`+9(`BIT_TMR_MAX`+1)); `rx_valid` (or `rx_err`) is 1 after that edge.
- Return to IDLE occurs at the stop sample, which is mid-stop-bit. A following start bit directly after the stop bit is therefore caught: back-to-back frames are supported.
- Accept to `rx_valid` low: 1 cycle. There is no combinational path from `rx_ready` to any output.
- Tolerated baud mismatch: ±4% total.

## Test plan
All scenarios use `BIT_TMR_MAX`=15, `HALF_MAX`=7, a 16-clock bit period, and line transitions on clock edges.
- Reset, then send 0xA5 with `rx_ready`=1:
  - `rx_valid` rises exactly 154 edges after E0 with `rx_data`=0xA5.
  - `rx_valid` falls one cycle later.
  - `rx_err`=`rx_overrun`=0 throughout.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap and `rx_ready`=1: three deliveries in order, each with the correct value and no errors.
- Send 0x3C with `rx_ready`=0, then send 0xC3:
  - `rx_data` stays 0x3C.
  - `rx_overrun` pulses once, on the 0xC3 stop-sample edge.
  - Raising `rx_ready` then clears `rx_valid`.
- Send 0x81 with the stop bit forced to 0 and the line held low for 40 clocks, then raised:
  - `rx_err` pulses once.
  - `rx_valid` stays 0.
  - There is no second `rx_err` and no spurious frame.
  - A following 0x7E is received correctly.
- Glitch the line low for 4 clocks (shorter than the half period): there is no output, and the FSM returns to IDLE. Separately, assert `RST` mid-DATA of a frame: all outputs are 0 on the next edge, and a frame after `RST` deasserts is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Byte-side handshake of the UART receiver: one-entry valid/ready output plus
// the error and overrun event pulses.
interface uart_rx_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_err;
   logic       rx_overrun;

   modport master (
      output rx_data, rx_valid, rx_err, rx_overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, rx_err, rx_overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: mid-bit sampling off a half-period start check, with a
// one-entry holding register on the byte output.
module uart_rx_ctrl #(
   parameter int BIT_TMR_MAX = 10416,
   parameter int HALF_MAX    = BIT_TMR_MAX / 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             UART_RX,
   uart_rx_ctrl_if.master   rx
);

   localparam logic [13:0] BIT_LAST  = 14'(BIT_TMR_MAX);
   localparam logic [13:0] HALF_LAST = 14'(HALF_MAX);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  sync_q, sync_d;
   logic [13:0] tmr_q, tmr_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic        ovr_q, ovr_d;

   logic rx_s;
   logic deliver;
   logic accept;

   assign rx_s   = sync_q[1];
   assign accept = valid_q & rx.rx_ready;

   always_comb begin
      sync_d   = {sync_q[0], UART_RX};
      state_d  = state_q;
      tmr_d    = tmr_q + 14'd1;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      err_d    = 1'b0;
      deliver  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               tmr_d   = '0;
            end
         end
         S_START: begin
            if (tmr_q == HALF_LAST) begin
               tmr_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tmr_q == BIT_LAST) begin
               tmr_d          = '0;
               shreg_d[idx_q] = rx_s;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tmr_q == BIT_LAST) begin
               tmr_d = '0;
               if (rx_s) begin
                  deliver = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // A line stuck low must go high before another start is honoured.
            if (rx_s) begin
               state_d = S_IDLE;
               tmr_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (deliver) begin
         if (!valid_q || accept) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q  <= 2'b11;
         state_q <= S_IDLE;
         tmr_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx.rx_data    = data_q;
   assign rx.rx_valid   = valid_q;
   assign rx.rx_err     = err_q;
   assign rx.rx_overrun = ovr_q;

endmodule
